// File: rtl/eq3_sweep_checker.sv
// Clocked stimulus sequencer and checker for a 3-input all-equal detector.
// Walks {a,b,c} through 000..111, holding each vector HOLD cycles, samples y
// on the last cycle of each window and tallies hits and mismatches.
module eq3_sweep_checker #(
  parameter int unsigned HOLD = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       y,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] hit_cnt,
  output logic [3:0] err_cnt,
  output logic       err_pulse
);

  typedef enum logic [1:0] {StIdle, StDrive, StDone} state_e;

  localparam logic [7:0] HoldLast = 8'(HOLD - 1);

  state_e     state_q, state_d;
  logic [2:0] vec_q, vec_d;
  logic [7:0] hold_q, hold_d;
  logic [3:0] hit_q, hit_d;
  logic [3:0] err_q, err_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic       err_pulse_q, err_pulse_d;
  logic       sample;
  logic       expected;
  logic       miss;

  // Next-state logic: sequencing, sampling and tallying.
  always_comb begin
    state_d     = state_q;
    vec_d       = vec_q;
    hold_d      = hold_q;
    hit_d       = hit_q;
    err_d       = err_q;
    done_d      = done_q;
    pass_d      = pass_q;
    sample      = (state_q == StDrive) && (hold_q == HoldLast);
    expected    = (vec_q == 3'b000) || (vec_q == 3'b111);
    miss        = sample && (y != expected);
    err_pulse_d = miss;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StDrive;
          vec_d   = 3'b000;
          hold_d  = 8'd0;
          hit_d   = 4'd0;
          err_d   = 4'd0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
        end
      end
      StDrive: begin
        if (sample) begin
          hit_d = hit_q + {3'b000, y};
          err_d = err_q + {3'b000, miss};
          if (vec_q == 3'b111) begin
            // Final verdict includes the sample taken on this edge.
            state_d = StDone;
            done_d  = 1'b1;
            pass_d  = (err_d == 4'd0);
          end else begin
            vec_d  = vec_q + 3'd1;
            hold_d = 8'd0;
          end
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      vec_q       <= 3'b000;
      hold_q      <= 8'd0;
      hit_q       <= 4'd0;
      err_q       <= 4'd0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      vec_q       <= vec_d;
      hold_q      <= hold_d;
      hit_q       <= hit_d;
      err_q       <= err_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_pulse_q <= err_pulse_d;
    end
  end

  // Output mapping.
  always_comb begin
    a         = vec_q[2];
    b         = vec_q[1];
    c         = vec_q[0];
    busy      = (state_q == StDrive);
    done      = done_q;
    pass      = pass_q;
    hit_cnt   = hit_q;
    err_cnt   = err_q;
    err_pulse = err_pulse_q;
  end

endmodule

// File: tb/tb_eq3_sweep_checker.sv
// Self-checking bench: two checkers (HOLD=5 and HOLD=1), each fed by a
// truth-table detector model, compared against a per-vector reference.
module tb_eq3_sweep_checker;

  logic       clk;
  logic       rst;
  logic [1:0] start_s;
  logic [7:0] tbl [2];
  wire  [1:0] y_w, a_w, b_w, c_w, busy_w, done_w, pass_w, ep_w;
  wire  [3:0] hit0, err0, hit1, err1;

  int n_vec;
  int n_err;

  assign y_w[0] = tbl[0][{a_w[0], b_w[0], c_w[0]}];
  assign y_w[1] = tbl[1][{a_w[1], b_w[1], c_w[1]}];

  eq3_sweep_checker #(.HOLD(5)) dut0 (
    .clk(clk), .rst(rst), .start(start_s[0]), .y(y_w[0]),
    .a(a_w[0]), .b(b_w[0]), .c(c_w[0]), .busy(busy_w[0]), .done(done_w[0]),
    .pass(pass_w[0]), .hit_cnt(hit0), .err_cnt(err0), .err_pulse(ep_w[0])
  );

  eq3_sweep_checker #(.HOLD(1)) dut1 (
    .clk(clk), .rst(rst), .start(start_s[1]), .y(y_w[1]),
    .a(a_w[1]), .b(b_w[1]), .c(c_w[1]), .busy(busy_w[1]), .done(done_w[1]),
    .pass(pass_w[1]), .hit_cnt(hit1), .err_cnt(err1), .err_pulse(ep_w[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int abc(input int sel);
    return {29'd0, a_w[sel], b_w[sel], c_w[sel]};
  endfunction

  function automatic int hit_of(input int sel);
    return (sel == 0) ? int'(hit0) : int'(hit1);
  endfunction

  function automatic int err_of(input int sel);
    return (sel == 0) ? int'(err0) : int'(err1);
  endfunction

  // Reference: all-equal golden per vector index.
  function automatic bit golden(input int v);
    return (v == 0) || (v == 7);
  endfunction

  // Full sweep on checker sel, checking every cycle against the reference.
  task automatic run_sweep(input int sel, input int hold, input bit keep_start);
    int hits, errs;
    bit last_miss;
    bit ybit;
    hits = 0;
    errs = 0;
    last_miss = 0;
    @(negedge clk);
    start_s[sel] = 1'b1;
    @(posedge clk);
    #1;
    if (!keep_start) start_s[sel] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < hold; j++) begin
        check("vec", abc(sel), i);
        check("busy", int'(busy_w[sel]), 1);
        check("done_low", int'(done_w[sel]), 0);
        if (j == 0) begin
          check("err_pulse", int'(ep_w[sel]), int'(last_miss));
          check("hit_mid", hit_of(sel), hits);
          check("err_mid", err_of(sel), errs);
        end else begin
          check("err_pulse_idle", int'(ep_w[sel]), 0);
        end
        @(posedge clk);
        #1;
      end
      ybit = tbl[sel][i];
      hits += int'(ybit);
      last_miss = (ybit != golden(i));
      errs += int'(last_miss);
    end
    start_s[sel] = 1'b0;
    check("done", int'(done_w[sel]), 1);
    check("busy_end", int'(busy_w[sel]), 0);
    check("pass", int'(pass_w[sel]), int'(errs == 0));
    check("hit", hit_of(sel), hits);
    check("err", err_of(sel), errs);
    check("err_pulse_last", int'(ep_w[sel]), int'(last_miss));
    check("vec_end", abc(sel), 7);
    @(posedge clk);
    #1;
    check("done_hold", int'(done_w[sel]), 1);
    check("hit_hold", hit_of(sel), hits);
    check("err_pulse_clr", int'(ep_w[sel]), 0);
    check("vec_hold", abc(sel), 7);
  endtask

  task automatic check_reset_state(input int sel);
    check("rst_vec", abc(sel), 0);
    check("rst_busy", int'(busy_w[sel]), 0);
    check("rst_done", int'(done_w[sel]), 0);
    check("rst_pass", int'(pass_w[sel]), 0);
    check("rst_hit", hit_of(sel), 0);
    check("rst_err", err_of(sel), 0);
    check("rst_ep", int'(ep_w[sel]), 0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    start_s = 2'b00;
    tbl[0] = 8'b1000_0001;
    tbl[1] = 8'b1000_0001;
    rst = 1'b1;
    #12;
    check_reset_state(0);
    check_reset_state(1);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state(0);

    // Correct detector, then y tied 0 and 1, on HOLD=5.
    run_sweep(0, 5, 1'b0);
    tbl[0] = 8'h00;
    run_sweep(0, 5, 1'b0);
    tbl[0] = 8'hFF;
    run_sweep(0, 5, 1'b0);

    // HOLD=1, correct detector, then start held through the sweep.
    run_sweep(1, 1, 1'b0);
    run_sweep(1, 1, 1'b1);
    tbl[0] = 8'b1000_0001;
    run_sweep(0, 5, 1'b1);

    // Randomized detector truth tables.
    for (int r = 0; r < 6; r++) begin
      tbl[0] = 8'($urandom);
      tbl[1] = 8'($urandom);
      run_sweep(0, 5, 1'($urandom_range(0, 1)));
      run_sweep(1, 1, 1'($urandom_range(0, 1)));
    end

    // Reset while vector 011 is driven on the HOLD=5 checker.
    tbl[0] = 8'b1000_0001;
    @(negedge clk);
    start_s[0] = 1'b1;
    @(posedge clk);
    #1;
    start_s[0] = 1'b0;
    repeat (17) @(posedge clk);
    #1;
    check("pre_rst_vec", abc(0), 3);
    #2;
    rst = 1'b1;
    #1;
    check_reset_state(0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state(0);
    run_sweep(0, 5, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
